// File: rtl/conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_feeder
// Description : Sweeps a WIDTH x HEIGHT convolution window over an
//               IN_W x IN_H feature map. For every output pixel it issues
//               one feature-memory and one weight-memory read per kernel tap.
//               The returned words go to the conv datapath two cycles after
//               issue, together with enables and pixel/tap tags.
// Ports       :
//   clk, rstn            clock, asynchronous active-low reset
//   start                one-cycle request to process a full map (IDLE only)
//   stall                downstream hold; freezes issue while high in RUN
//   fm_addr / fm_rdata   feature memory read port (1-cycle read latency)
//   wt_addr / wt_rdata   weight memory read port (1-cycle read latency)
//   in_data, in_factor   registered feature/weight words to the datapath
//   ena_conv, ena_adder  qualify in_data/in_factor
//   first_tap, last_tap  tap 0 / last tap of the current output pixel
//   pix_x, pix_y         output pixel the current tap belongs to
//   busy, done           high outside IDLE / one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_feeder #(
  parameter int BITWIDTH = 8,
  parameter int WIDTH    = 5,
  parameter int HEIGHT   = 5,
  parameter int CHANNEL  = 6,
  parameter int IN_W     = 12,
  parameter int IN_H     = 12,
  parameter int ADDR_W   = 8,
  localparam int OUT_W   = IN_W - WIDTH + 1,
  localparam int OUT_H   = IN_H - HEIGHT + 1,
  localparam int WT_AW   = ($clog2(WIDTH * HEIGHT) > 0) ? $clog2(WIDTH * HEIGHT) : 1,
  localparam int PXW     = ($clog2(OUT_W) > 0) ? $clog2(OUT_W) : 1,
  localparam int PYW     = ($clog2(OUT_H) > 0) ? $clog2(OUT_H) : 1,
  localparam int DW      = BITWIDTH * CHANNEL
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stall,
  output logic [ADDR_W-1:0] fm_addr,
  input  logic [DW-1:0]     fm_rdata,
  output logic [WT_AW-1:0]  wt_addr,
  input  logic [DW-1:0]     wt_rdata,
  output logic [DW-1:0]     in_data,
  output logic [DW-1:0]     in_factor,
  output logic              ena_conv,
  output logic              ena_adder,
  output logic              first_tap,
  output logic              last_tap,
  output logic [PXW-1:0]    pix_x,
  output logic [PYW-1:0]    pix_y,
  output logic              busy,
  output logic              done
);

  localparam int KXW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam int KYW = ($clog2(HEIGHT) > 0) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Window counters, innermost first: kx, ky, ox, oy
  logic [KXW-1:0] r_kx;
  logic [KYW-1:0] r_ky;
  logic [PXW-1:0] r_ox;
  logic [PYW-1:0] r_oy;

  logic           r_drain_cnt;

  logic           w_issue;
  logic           w_kx_end;
  logic           w_ky_end;
  logic           w_ox_end;
  logic           w_oy_end;
  logic           w_tap_first;
  logic           w_tap_last;
  logic           w_map_last;

  // Stage-1 pipeline: tags travel alongside the outstanding memory read
  logic           r_v1;
  logic           r_first1;
  logic           r_last1;
  logic [PXW-1:0] r_px1;
  logic [PYW-1:0] r_py1;

  assign w_issue     = (r_state == S_RUN) && !stall;
  assign w_kx_end    = (r_kx == KXW'(WIDTH - 1));
  assign w_ky_end    = (r_ky == KYW'(HEIGHT - 1));
  assign w_ox_end    = (r_ox == PXW'(OUT_W - 1));
  assign w_oy_end    = (r_oy == PYW'(OUT_H - 1));
  assign w_tap_first = (r_kx == '0) && (r_ky == '0);
  assign w_tap_last  = w_kx_end && w_ky_end;
  assign w_map_last  = w_tap_last && w_ox_end && w_oy_end;

  // Addresses follow the counters directly, so a stall holds them for free
  // and reset drives them to zero along with the counters.
  assign fm_addr = (ADDR_W'(r_oy) + ADDR_W'(r_ky)) * ADDR_W'(IN_W)
                 + ADDR_W'(r_ox) + ADDR_W'(r_kx);
  assign wt_addr = WT_AW'(r_ky) * WT_AW'(WIDTH) + WT_AW'(r_kx);

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && w_map_last) w_state_nxt = S_DRAIN;
      // Two drain cycles let the final tap clear the 2-stage pipeline
      S_DRAIN: if (r_drain_cnt) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drain_cnt <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      r_drain_cnt <= ~r_drain_cnt;
    end else begin
      r_drain_cnt <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Window counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_kx <= '0;
      r_ky <= '0;
      r_ox <= '0;
      r_oy <= '0;
    end else if (r_state == S_IDLE) begin
      r_kx <= '0;
      r_ky <= '0;
      r_ox <= '0;
      r_oy <= '0;
    end else if (w_issue) begin
      if (!w_kx_end) begin
        r_kx <= r_kx + KXW'(1);
      end else begin
        r_kx <= '0;
        if (!w_ky_end) begin
          r_ky <= r_ky + KYW'(1);
        end else begin
          r_ky <= '0;
          if (!w_ox_end) begin
            r_ox <= r_ox + PXW'(1);
          end else begin
            r_ox <= '0;
            if (!w_oy_end) begin
              r_oy <= r_oy + PYW'(1);
            end else begin
              r_oy <= '0;
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: tags wait while memories return data (tags forced to 0 unless
  // a tap was issued, so the output tags are clean on idle cycles)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1     <= 1'b0;
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
      r_px1    <= '0;
      r_py1    <= '0;
    end else begin
      r_v1     <= w_issue;
      r_first1 <= w_issue && w_tap_first;
      r_last1  <= w_issue && w_tap_last;
      r_px1    <= w_issue ? r_ox : '0;
      r_py1    <= w_issue ? r_oy : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: capture memory data; words hold when no tap is delivered
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_data   <= '0;
      in_factor <= '0;
      ena_conv  <= 1'b0;
      ena_adder <= 1'b0;
      first_tap <= 1'b0;
      last_tap  <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      ena_conv  <= r_v1;
      ena_adder <= r_v1;
      first_tap <= r_first1;
      last_tap  <= r_last1;
      pix_x     <= r_px1;
      pix_y     <= r_py1;
      if (r_v1) begin
        in_data   <= fm_rdata;
        in_factor <= wt_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_feeder
// Description : Directed bench for conv_window_feeder with default parameters.
//               Synchronous memory models return address-derived patterns; a
//               tap-index model predicts addresses, data and tags per tap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_feeder;

  localparam int DW    = 48;
  localparam int NTAPS = 1600;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          stall;
  logic [7:0]    fm_addr;
  logic [DW-1:0] fm_rdata;
  logic [4:0]    wt_addr;
  logic [DW-1:0] wt_rdata;
  logic [DW-1:0] in_data;
  logic [DW-1:0] in_factor;
  logic          ena_conv;
  logic          ena_adder;
  logic          first_tap;
  logic          last_tap;
  logic [2:0]    pix_x;
  logic [2:0]    pix_y;
  logic          busy;
  logic          done;

  conv_window_feeder dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stall     (stall),
    .fm_addr   (fm_addr),
    .fm_rdata  (fm_rdata),
    .wt_addr   (wt_addr),
    .wt_rdata  (wt_rdata),
    .in_data   (in_data),
    .in_factor (in_factor),
    .ena_conv  (ena_conv),
    .ena_adder (ena_adder),
    .first_tap (first_tap),
    .last_tap  (last_tap),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fpat(input int a);
    logic [DW-1:0] r;
    for (int c = 0; c < 6; c++) r[c*8 +: 8] = 8'(a + c * 37);
    return r;
  endfunction

  function automatic logic [DW-1:0] wpat(input int a);
    logic [DW-1:0] r;
    for (int c = 0; c < 6; c++) r[c*8 +: 8] = 8'(160 + a * 3 + c);
    return r;
  endfunction

  // Synchronous read memories: data valid one cycle after the address
  always @(posedge clk) begin
    fm_rdata <= fpat(int'(fm_addr));
    wt_rdata <= wpat(int'(wt_addr));
  end

  // Model state
  int            k = 0;
  int            ena_cnt = 0;
  int            first_ena_cyc = 0;
  int            last_ena_cyc = 0;
  int            done_cnt = 0;
  logic [DW-1:0] held_d = '0;
  logic [DW-1:0] held_f = '0;
  logic [7:0]    h1_fm = '0, h2_fm = '0;
  logic [4:0]    h1_wt = '0, h2_wt = '0;

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    int kx, ky, ox, oy, fa, wa;
    logic [127:0] got, exp;
    if (ena_conv) begin
      kx = k % 5;
      ky = (k / 5) % 5;
      ox = (k / 25) % 8;
      oy = k / 200;
      fa = (oy + ky) * 12 + ox + kx;
      wa = ky * 5 + kx;
      got = {h2_fm, h2_wt, in_data, in_factor, ena_adder, first_tap, last_tap, pix_x, pix_y};
      exp = {8'(fa), 5'(wa), fpat(fa), wpat(wa), 1'b1, (kx == 0 && ky == 0),
             (kx == 4 && ky == 4), 3'(ox), 3'(oy)};
      check("tap", got, exp);
      case (k)
        4:   check("k4_fm", {h2_fm, h2_wt}, {8'd4, 5'd4});
        5:   check("k5_fm", {h2_fm, h2_wt}, {8'd12, 5'd5});
        24:  check("k24_fm_last", {h2_fm, h2_wt, last_tap}, {8'd52, 5'd24, 1'b1});
        175: check("pix7_0", {h2_fm, first_tap, pix_x, pix_y}, {8'd7, 1'b1, 3'd7, 3'd0});
        200: check("pix0_1", {h2_fm, first_tap, pix_x, pix_y}, {8'd12, 1'b1, 3'd0, 3'd1});
        default: ;
      endcase
      held_d = in_data;
      held_f = in_factor;
      if (ena_cnt == 0) first_ena_cyc = cyc;
      last_ena_cyc = cyc;
      ena_cnt++;
      k++;
    end else begin
      check("idle_outs", {ena_adder, first_tap, last_tap, pix_x, pix_y, in_data, in_factor},
            {9'd0, held_d, held_f});
    end
    if (done) begin
      check("done_pulse", {busy, 32'(cyc - last_ena_cyc)}, {1'b1, 32'd1});
      done_cnt++;
    end
    h2_fm = h1_fm;
    h2_wt = h1_wt;
    h1_fm = fm_addr;
    h1_wt = wt_addr;
  end

  function automatic logic [127:0] all_outs();
    return {fm_addr, wt_addr, in_data, in_factor, ena_conv, ena_adder, first_tap,
            last_tap, pix_x, pix_y, busy, done};
  endfunction

  task automatic clear_model();
    k = 0;
    ena_cnt = 0;
    done_cnt = 0;
    first_ena_cyc = 0;
    last_ena_cyc = 0;
  endtask

  task automatic pulse_start(output int scyc);
    @(posedge clk); #1;
    start = 1'b1;
    scyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    logic seen;
    n0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != n0) break;
    end
    #1;
    seen = (done_cnt != n0);
    check("done_seen", seen, 1'b1);
    // Extra idle time exposes any spurious second done
    repeat (10) @(posedge clk);
    #1;
    check("idle_after_done", busy, 1'b0);
  endtask

  task automatic run_stats(input string tag, input int scyc, input int nstall);
    check({tag, "_count"}, ena_cnt, NTAPS);
    check({tag, "_latency"}, first_ena_cyc - scyc, 3);
    check({tag, "_span"}, last_ena_cyc - first_ena_cyc + 1, NTAPS + nstall);
    check({tag, "_ndone"}, done_cnt, 1);
  endtask

  initial begin
    int scyc;
    rstn  = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 128'd0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Run A: plain full map
    clear_model();
    pulse_start(scyc);
    check("busy_after_start", busy, 1'b1);
    wait_done(NTAPS + 100);
    run_stats("runA", scyc, 0);

    // Run B: 3-cycle stall mid-pixel and ignored start pulses
    clear_model();
    pulse_start(scyc);
    repeat (103) @(posedge clk);
    #1;
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (50) @(posedge clk);
      pulse_start(scyc);
      check("busy_run", busy, 1'b1);
    end
    // Latency reference for run B is the first start; recompute from taps seen
    scyc = first_ena_cyc - 3;
    wait_done(NTAPS + 200);
    run_stats("runB", scyc, 3);

    // Run C: reset around tap 500, then a clean restart
    clear_model();
    pulse_start(scyc);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (ena_cnt >= 500) break;
    end
    check("reached_500", ena_cnt >= 500, 1'b1);
    rstn = 1'b0;
    #1;
    check("rst_async", all_outs(), 128'd0);
    held_d = '0;
    held_f = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_rst", all_outs(), 128'd0);
    pulse_start(scyc);
    wait_done(NTAPS + 100);
    run_stats("runC", scyc, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
